// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory answering one load/store request at a time
//   over valid/ready request and response channels, with a fixed number of
//   wait states per access and per-response error flagging.
//
// Parameters
//   ADDR_WIDTH   word-address bits; depth is 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data, word-aligned byte lanes
//   req_be     in   byte enables, bit i covers bits 8i+7:8i
//   rsp_valid  out  response present
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  request rejected
//   busy       out  not in IDLE
//   err_count  out  saturating count of error responses
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned HI_LSB = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;

   logic                  r_we;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;

   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_busy;
   logic [7:0]            r_err_count;

   logic [31:0]           r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_access;
   logic                  w_err;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_mem_word;
   logic [31:0]           w_merged;

   // Request capture and access timing
   assign w_accept   = (r_state == S_IDLE) && req_valid;
   assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);

   // Reject out-of-range, misaligned and empty-enable requests
   assign w_err      = ((r_addr >> HI_LSB) != 32'd0) || (r_addr[1:0] != 2'b00)
                       || (r_be == 4'b0000);
   assign w_idx      = r_addr[ADDR_WIDTH+1:2];
   assign w_mem_word = r_mem[w_idx];
   assign w_mem_we   = w_access && r_we && !w_err;

   // Byte-lane merge of store data over the current word
   always_comb begin
      w_merged = w_mem_word;
      for (int i = 0; i < 4; i++) begin
         if (r_be[i]) begin
            w_merged[8*i +: 8] = r_wdata[8*i +: 8];
         end
      end
   end

   // FSM next-state and wait counter
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request capture, response and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end
         if (w_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (!r_we && !w_err) ? w_mem_word : 32'd0;
            if (w_err && (r_err_count != 8'hFF)) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_rsp_valid <= (w_state_nxt == S_RESP);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Storage array; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;
   assign err_count = r_err_count;

endmodule
